sprite_palette_engine: RTL and testbench

Parametrised, runtime-writable palette lookup for sprite and background pixel indices, with multiple selectable banks. Each sprite class (player, enemy colour variants) gets its own bank instead of a hard-coded ROM. Adds per-frame animation effects: hit-flash and fade in/out. Sits between the sprite pixel fetch and the VGA colour mux, ahead of the transparency compositor.

---
 rtl/sprite_palette_engine.sv | 158 +++++++++++++++
 tb/tb_sprite_palette_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_engine.sv
// Banked runtime-writable sprite palette with hit-flash and fade effects.
// Two-stage lookup: entry fetch, then flash/fade colour processing.
module sprite_palette_engine #(
  parameter int          IDX_W             = 3,
  parameter int          BANKS             = 4,
  parameter int          BANK_W            = 2,
  parameter int          TRANSPARENT_INDEX = 0,
  parameter logic [11:0] FLASH_RGB         = 12'hEEE,
  parameter int          FLASH_FRAMES      = 6,
  parameter int          FADE_STEP         = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [11:0]       wr_rgb,
  input  logic              rd_valid,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic              flash_trig,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic              out_valid,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              transparent,
  output logic              flash_active,
  output logic              fade_busy
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int FL_CLG  = $clog2(FLASH_FRAMES + 1);
  localparam int FL_W    = (FL_CLG > 3) ? FL_CLG : 3;
  localparam logic [4:0] FULL = 5'd16;
  localparam logic [4:0] STEP = 5'(FADE_STEP);

  logic [11:0] pal_q [BANKS][ENTRIES];
  logic [11:0] pal_d [BANKS][ENTRIES];

  logic        s1_v_q, s1_v_d;
  logic [11:0] s1_rgb_q, s1_rgb_d;
  logic        s1_tr_q, s1_tr_d;

  logic        ov_q, ov_d;
  logic [11:0] rgb_q, rgb_d;
  logic        tr_q, tr_d;

  logic [FL_W-1:0] fl_q, fl_d;
  logic [4:0]      lvl_q, lvl_d;
  logic [4:0]      tgt_q, tgt_d;

  function automatic logic [3:0] scale(input logic [3:0] c,
                                       input logic [4:0] l);
    logic [8:0] p;
    p = {5'b0, c} * {4'b0, l};
    return p[7:4];
  endfunction

  // Palette write port; out-of-range banks are dropped.
  always_comb begin
    pal_d = pal_q;
    if (wr_en && (int'(wr_bank) < BANKS))
      pal_d[wr_bank][wr_index] = wr_rgb;
  end

  // Stage 1: fetch entry from the pre-write palette contents.
  always_comb begin
    s1_v_d   = rd_valid;
    s1_rgb_d = 12'h000;
    s1_tr_d  = 1'b0;
    if (int'(rd_bank) < BANKS) begin
      s1_rgb_d = pal_q[rd_bank][rd_index];
      s1_tr_d  = (rd_index == IDX_W'(TRANSPARENT_INDEX));
    end
  end

  // Stage 2: flash substitution then fade scaling; hold when idle.
  always_comb begin
    logic [11:0] px;
    ov_d  = s1_v_q;
    rgb_d = rgb_q;
    tr_d  = tr_q;
    px    = (fl_q != '0) ? FLASH_RGB : s1_rgb_q;
    if (s1_v_q) begin
      tr_d = s1_tr_q;
      if (s1_tr_q)
        rgb_d = s1_rgb_q;
      else
        rgb_d = {scale(px[11:8], lvl_q),
                 scale(px[7:4], lvl_q),
                 scale(px[3:0], lvl_q)};
    end
  end

  // Flash frame counter; a trigger reloads even on a tick.
  always_comb begin
    fl_d = fl_q;
    if (flash_trig)
      fl_d = FL_W'(FLASH_FRAMES);
    else if (frame_tick && fl_q != '0)
      fl_d = fl_q - FL_W'(1);
  end

  // Fade level steps toward target per frame, saturating.
  always_comb begin
    lvl_d = lvl_q;
    tgt_d = tgt_q;
    if (fade_start) begin
      tgt_d = fade_dir ? FULL : 5'd0;
    end else if (frame_tick) begin
      if (lvl_q < tgt_q)
        lvl_d = (tgt_q - lvl_q > STEP) ? lvl_q + STEP : tgt_q;
      else if (lvl_q > tgt_q)
        lvl_d = (lvl_q - tgt_q > STEP) ? lvl_q - STEP : tgt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < BANKS; b++)
        for (int i = 0; i < ENTRIES; i++)
          pal_q[b][i] <= 12'h000;
      s1_v_q   <= 1'b0;
      s1_rgb_q <= 12'h000;
      s1_tr_q  <= 1'b0;
      ov_q     <= 1'b0;
      rgb_q    <= 12'h000;
      tr_q     <= 1'b0;
      fl_q     <= '0;
      lvl_q    <= FULL;
      tgt_q    <= FULL;
    end else begin
      pal_q    <= pal_d;
      s1_v_q   <= s1_v_d;
      s1_rgb_q <= s1_rgb_d;
      s1_tr_q  <= s1_tr_d;
      ov_q     <= ov_d;
      rgb_q    <= rgb_d;
      tr_q     <= tr_d;
      fl_q     <= fl_d;
      lvl_q    <= lvl_d;
      tgt_q    <= tgt_d;
    end
  end

  assign out_valid    = ov_q;
  assign red          = rgb_q[11:8];
  assign green        = rgb_q[7:4];
  assign blue         = rgb_q[3:0];
  assign transparent  = tr_q;
  assign flash_active = (fl_q != '0);
  assign fade_busy    = (lvl_q != tgt_q);

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Directed bench for sprite_palette_engine.
// Expected colours are hand-computed constants.
module tb_sprite_palette_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, wr_en, rd_valid;
  logic [1:0]  wr_bank, rd_bank;
  logic [2:0]  wr_index, rd_index;
  logic [11:0] wr_rgb;
  logic        flash_trig, fade_start, fade_dir;
  logic        out_valid, transparent, flash_active, fade_busy;
  logic [3:0]  red, green, blue;

  int checks = 0;
  int errors = 0;

  sprite_palette_engine dut (
    .Clk(clk), .Reset(rst), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index),
    .wr_rgb(wr_rgb), .rd_valid(rd_valid), .rd_bank(rd_bank),
    .rd_index(rd_index), .flash_trig(flash_trig),
    .fade_start(fade_start), .fade_dir(fade_dir),
    .out_valid(out_valid), .red(red), .green(green),
    .blue(blue), .transparent(transparent),
    .flash_active(flash_active), .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] b, input logic [2:0] i,
                    input logic [11:0] c);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_rgb = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] b,
                    input logic [2:0] i, input logic [11:0] exp,
                    input logic tr);
    rd_valid = 1'b1; rd_bank = b; rd_index = i;
    step();
    rd_valid = 1'b0;
    step();
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(exp));
    chk({tag, "_tr"}, 32'(transparent), 32'(tr));
  endtask

  logic [3:0]  fo_ch [8] = '{4'hD, 4'hB, 4'h9, 4'h7,
                             4'h5, 4'h3, 4'h1, 4'h0};
  logic [11:0] b2b [8]   = '{12'h123, 12'h234, 12'h345, 12'h456,
                             12'h567, 12'h678, 12'h789, 12'h89A};

  initial begin
    rst = 1'b1; frame_tick = 0; wr_en = 0; rd_valid = 0;
    wr_bank = 0; rd_bank = 0; wr_index = 0; rd_index = 0;
    wr_rgb = 0; flash_trig = 0; fade_start = 0; fade_dir = 0;
    step(); step();
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_rgb", 32'({red, green, blue}), 0);
    chk("rst_tr", 32'(transparent), 0);
    chk("rst_fl", 32'(flash_active), 0);
    chk("rst_fb", 32'(fade_busy), 0);
    rst = 1'b0;
    step();

    wr(2'd1, 3'd2, 12'hDA9);
    rd("b1i2", 2'd1, 3'd2, 12'hDA9, 1'b0);
    step();
    chk("hold_v", 32'(out_valid), 0);
    chk("hold_rgb", 32'({red, green, blue}), 32'h0DA9);

    wr_en = 1'b1; wr_bank = 0; wr_index = 3'd2; wr_rgb = 12'h421;
    rd("rbw_old", 2'd0, 3'd2, 12'h000, 1'b0);
    wr_en = 1'b0;
    rd("rbw_new", 2'd0, 3'd2, 12'h421, 1'b0);

    wr(2'd0, 3'd0, 12'h0E0);
    rd("trans", 2'd0, 3'd0, 12'h0E0, 1'b1);

    flash_trig = 1'b1; step(); flash_trig = 1'b0;
    chk("fl_on", 32'(flash_active), 1);
    rd("fl_px", 2'd0, 3'd2, 12'hEEE, 1'b0);
    rd("fl_tr", 2'd0, 3'd0, 12'h0E0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("fl_t%0d", k), 32'(flash_active), 32'(k < 6));
    end
    rd("fl_off", 2'd0, 3'd2, 12'h421, 1'b0);

    tick(); tick();
    flash_trig = 1'b1; frame_tick = 1'b1; step();
    flash_trig = 1'b0; frame_tick = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    chk("fl_co_end", 32'(flash_active), 0);
    flash_trig = 1'b1; step(); flash_trig = 1'b0;
    tick(); tick();
    flash_trig = 1'b1; frame_tick = 1'b1; step();
    flash_trig = 1'b0; frame_tick = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("fl_co_5", 32'(flash_active), 1);
    tick();
    chk("fl_co_6", 32'(flash_active), 0);

    wr(2'd0, 3'd3, 12'hB21);
    wr(2'd0, 3'd4, 12'hFFF);
    fade_dir = 1'b0; fade_start = 1'b1; step(); fade_start = 1'b0;
    chk("fo_busy0", 32'(fade_busy), 1);
    rd("fo_l16", 2'd0, 3'd4, 12'hFFF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("fo_busy%0d", k + 1), 32'(fade_busy),
          32'(k < 7));
      rd($sformatf("fo_t%0d", k + 1), 2'd0, 3'd4,
         {fo_ch[k], fo_ch[k], fo_ch[k]}, 1'b0);
      if (k == 3) rd("fo_b21_l8", 2'd0, 3'd3, 12'h510, 1'b0);
    end
    rd("fo_b21_l0", 2'd0, 3'd3, 12'h000, 1'b0);
    rd("fo_tr_l0", 2'd0, 3'd0, 12'h0E0, 1'b1);

    fade_dir = 1'b1; fade_start = 1'b1; step(); fade_start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("fi_done", 32'(fade_busy), 0);
    fade_dir = 1'b0; fade_start = 1'b1; step(); fade_start = 1'b0;
    tick(); tick(); tick();
    rd("rt_l10", 2'd0, 3'd4, 12'h999, 1'b0);
    fade_dir = 1'b1; fade_start = 1'b1; step(); fade_start = 1'b0;
    tick();
    rd("rt_l12", 2'd0, 3'd4, 12'hBBB, 1'b0);
    tick();
    rd("rt_l14", 2'd0, 3'd4, 12'hDDD, 1'b0);
    chk("rt_busy", 32'(fade_busy), 1);
    tick();
    rd("rt_l16", 2'd0, 3'd4, 12'hFFF, 1'b0);
    chk("rt_idle", 32'(fade_busy), 0);

    fade_dir = 1'b0; fade_start = 1'b1; step(); fade_start = 1'b0;
    tick(); tick();
    flash_trig = 1'b1;
    rd_valid = 1'b1; rd_bank = 0; rd_index = 3'd4;
    step();
    flash_trig = 1'b0; rd_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mr_ov0", 32'(out_valid), 0);
    rst = 1'b0;
    step();
    chk("mr_ov1", 32'(out_valid), 0);
    chk("mr_fb", 32'(fade_busy), 0);
    chk("mr_fl", 32'(flash_active), 0);
    rd("mr_b0i4", 2'd0, 3'd4, 12'h000, 1'b0);
    rd("mr_b1i2", 2'd1, 3'd2, 12'h000, 1'b0);

    for (int i = 0; i < 8; i++) wr(2'd2, 3'(i), b2b[i]);
    for (int c = 0; c <= 10; c++) begin
      if (c == 1 || c == 10)
        chk($sformatf("bb_idle%0d", c), 32'(out_valid), 0);
      if (c >= 2 && c < 10) begin
        chk($sformatf("bb_v%0d", c - 2), 32'(out_valid), 1);
        chk($sformatf("bb_rgb%0d", c - 2),
            32'({red, green, blue}), 32'(b2b[c - 2]));
        chk($sformatf("bb_tr%0d", c - 2), 32'(transparent),
            32'(c == 2));
      end
      if (c < 8) begin
        rd_valid = 1'b1; rd_bank = 2'd2; rd_index = 3'(c);
      end else begin
        rd_valid = 1'b0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
